// File: rtl/pc_fetch.sv
// pc_fetch -- program counter and instruction fetch sequencer.
//
// Holds an 8-bit PC, reads one instruction byte per fetch from an external
// instruction memory, presents it downstream until consumed, then advances
// the PC sequentially (PC+1, wrapping at 256) or to a branch target. A
// fetched HALT_OPCODE that is consumed stops the sequencer until reset.
//
// Handshakes:
//   imem_req/imem_ack   : request held with a stable address while in FETCH;
//                         the cycle imem_ack is high, imem_data is captured.
//                         imem_ack is ignored whenever imem_req is low.
//   instr_valid/instr_ready : instr is held stable while instr_valid is high;
//                         the cycle both are high the instruction is consumed.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               leave IDLE and begin fetching (ignored elsewhere)
//   imem_req, imem_addr instruction memory read request / address (= PC)
//   imem_ack, imem_data memory response
//   instr_valid, instr  fetched instruction towards downstream
//   instr_ready         downstream consume strobe
//   branch_valid, branch_target  redirect applied when instr is consumed
//   pc_seq              PC+1 (sequential input of the next-PC mux)
//   pc_sel              next-PC mux select, 1 = branch_target
//   halted              HALT_OPCODE consumed, fetching stopped
//   fetch_err           one-cycle pulse on fetch timeout
//
// Build option: define FETCH_TIMEOUT_EN to enable the fetch timeout. Without
// it, FETCH waits for imem_ack indefinitely and fetch_err is tied low.

module pc_fetch #(
   parameter logic [7:0] RESET_PC    = 8'h00,
   parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       imem_req,
   output logic [7:0] imem_addr,
   input  logic       imem_ack,
   input  logic [7:0] imem_data,
   output logic       instr_valid,
   output logic [7:0] instr,
   input  logic       instr_ready,
   input  logic       branch_valid,
   input  logic [7:0] branch_target,
   output logic [7:0] pc_seq,
   output logic       pc_sel,
   output logic       halted,
   output logic       fetch_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] pc;
   logic [7:0] pc_nxt;
   logic [7:0] instr_q;
   logic [7:0] instr_nxt;
   logic       timeout;

`ifdef FETCH_TIMEOUT_EN
   // Counts FETCH cycles that went by without an acknowledge. When it has
   // seen 15 such cycles, the 16th cycle is the timeout cycle: the request is
   // withdrawn for that cycle, fetch_err pulses, and the count restarts so the
   // same address is requested again on the following cycle.
   logic [3:0] wait_cnt;
   logic [3:0] wait_cnt_nxt;

   assign timeout = (state == S_FETCH) && (wait_cnt == 4'hF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 4'h0;
      end else begin
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      wait_cnt_nxt = 4'h0;
      if (state == S_FETCH && !timeout && !imem_ack) begin
         wait_cnt_nxt = wait_cnt + 4'h1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // State, PC and instruction registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         pc      <= RESET_PC;
         instr_q <= 8'h00;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         instr_q <= instr_nxt;
      end
   end

   // Next-state, next-PC and instruction capture.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      instr_nxt = instr_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            // During the timeout cycle the request is low, so any ack is
            // not a response to this fetch and is ignored.
            if (!timeout && imem_ack) begin
               instr_nxt = imem_data;
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (instr_ready) begin
               if (instr_q == HALT_OPCODE) begin
                  state_nxt = S_HALT;
               end else begin
                  pc_nxt    = pc_sel ? branch_target : pc_seq;
                  state_nxt = S_FETCH;
               end
            end
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from registered state only, except pc_sel which
   // follows branch_valid combinationally while an instruction is held.
   assign pc_seq      = pc + 8'd1;
   assign pc_sel      = branch_valid && (state == S_HOLD);
   assign imem_req    = (state == S_FETCH) && !timeout;
   assign imem_addr   = pc;
   assign instr_valid = (state == S_HOLD);
   assign instr       = instr_q;
   assign halted      = (state == S_HALT);
   assign fetch_err   = timeout;

endmodule
